// File: rtl/disp_pkg.sv
// Segment constants and anode helpers for the multiplexed 7-segment display.
// All patterns are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package disp_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // All anodes off (active-low) for an n-digit display, LSB aligned.
    function automatic logic [31:0] AN_OFF(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low 7-segment decoder; dp bit is always off.
// Codes 10..15 show a minus sign so bad counter values are visible.
module bcd_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    // Digit lookup, illegal codes fall through to the minus sign
    always_comb begin
        o_seg = SEG_MINUS;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_MINUS;
        endcase
    end

endmodule

// File: rtl/disp_mux_bcd.sv
// Multiplexed common-anode 7-segment driver for packed BCD digits.
// Loads are held in a pending register and promoted to the displayed
// shadow only at frame boundaries, so a frame never mixes old and new digits.
// Optional: define LZ_BLANK_EN for leading-zero suppression.
module disp_mux_bcd
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0] L_AN_OFF = N_DIGITS'(AN_OFF(N_DIGITS));

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_pend;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic                    r_pend_vld;
    logic [4*N_DIGITS-1:0]   r_shadow;
    logic [N_DIGITS-1:0]     r_dp_shadow;

    logic                    w_slot_end;
    logic                    w_frame;
    logic [3:0]              w_digit;
    logic [7:0]              w_seg;
    logic [N_DIGITS-1:0]     w_an_sel;
    logic [N_DIGITS-1:0]     w_show;

    assign w_slot_end = (r_cnt == CW'(PRESCALE - 1));
    assign w_frame    = w_slot_end && (r_idx == IW'(N_DIGITS - 1));
    assign w_digit    = r_shadow[4*r_idx +: 4];
    assign w_an_sel   = ~(N_DIGITS'(1) << r_idx);

    bcd_to_sseg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

`ifdef LZ_BLANK_EN
    // Show a digit once a nonzero digit or lit dp has been seen at or above it
    always_comb begin
        logic v_keep;
        w_show = '0;
        v_keep = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            v_keep    = v_keep | (r_shadow[4*i +: 4] != 4'd0) | r_dp_shadow[i] | (i == 0);
            w_show[i] = v_keep;
        end
    end
`else
    assign w_show = '1;
`endif

    // Prescaler and digit index; idx steps when a slot completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Pending/shadow capture; a load on the boundary bypasses pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend      <= '0;
            r_pend_dp   <= '0;
            r_pend_vld  <= 1'b0;
            r_shadow    <= '0;
            r_dp_shadow <= '0;
        end else if (load && w_frame) begin
            r_shadow    <= bcd_in;
            r_dp_shadow <= dp_in;
            r_pend_vld  <= 1'b0;
        end else if (load) begin
            r_pend      <= bcd_in;
            r_pend_dp   <= dp_in;
            r_pend_vld  <= 1'b1;
        end else if (w_frame && r_pend_vld) begin
            r_shadow    <= r_pend;
            r_dp_shadow <= r_pend_dp;
            r_pend_vld  <= 1'b0;
        end
    end

    // Registered pin drive: blank window, suppressed digits, else active digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= L_AN_OFF;
            sseg       <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_frame;
            if ((int'(r_cnt) < BLANK) || !w_show[r_idx]) begin
                an   <= L_AN_OFF;
                sseg <= SEG_BLANK;
            end else begin
                an   <= w_an_sel;
                sseg <= w_seg & {~r_dp_shadow[r_idx], 7'h7F};
            end
        end
    end

endmodule
